// File: rtl/muller_c_pkg.sv
// Shared types and default constants for the Muller C-element handshake driver.
package muller_c_pkg;

    // Four-phase handshake sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        RISE,
        WAIT_HI,
        FALL,
        WAIT_LO
    } hs_state_e;

    localparam int unsigned DEF_N_IN        = 2;
    localparam int unsigned DEF_TIMEOUT     = 200;
    localparam int unsigned DEF_STAGGER_GAP = 4;

endpackage : muller_c_pkg

// File: rtl/muller_c_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous C-element output.
module muller_c_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; the last flop is the clean copy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : muller_c_sync

// File: rtl/muller_c_hs_driver.sv
// Four-phase stimulus driver for a Muller C-element: raises all inputs, waits
// for the output to rise, lowers all inputs, waits for it to fall, repeats.
// Counts handshakes, tracks worst-case response latency and flags timeouts and
// premature output transitions.
// Optional build macro MULLER_HS_STAGGER_EN: raise/lower the inputs one at a
// time (LSB first, STAGGER_GAP cycles apart) to exercise the C-element hold state.
module muller_c_hs_driver
    import muller_c_pkg::*;
#(
    parameter int unsigned N_IN        = DEF_N_IN,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STAGGER_GAP = DEF_STAGGER_GAP
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [CNT_W-1:0]     n_cycles_i,
    input  logic                 c_out_i,
    output logic [N_IN-1:0]      c_in_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     cycles_done_o,
    output logic [TIMEOUT_W-1:0] lat_max_o,
    output logic                 err_timeout_o,
    output logic                 err_premature_o
);

`ifdef MULLER_HS_STAGGER_EN
    localparam int unsigned IDX_W = $clog2(N_IN + 1);
    localparam int unsigned GAP_W = $clog2(STAGGER_GAP + 1);
    // Only bit 0 moves on entry to RISE/FALL; the rest follow one per gap.
    localparam logic [N_IN-1:0] RISE_ENTRY = N_IN'(1);
    localparam logic [N_IN-1:0] FALL_ENTRY = ~N_IN'(1);
`else
    localparam logic [N_IN-1:0] RISE_ENTRY = '1;
    localparam logic [N_IN-1:0] FALL_ENTRY = '0;
`endif

    localparam logic [TIMEOUT_W-1:0] TIMER_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = TIMEOUT_W'(TIMEOUT);

    hs_state_e            state_q, state_d;
    logic [N_IN-1:0]      c_in_q, c_in_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [TIMEOUT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     ncyc_q, ncyc_d;
    logic                 err_to_q, err_to_d;
    logic                 err_pre_q, err_pre_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic                 c_sync;
`ifdef MULLER_HS_STAGGER_EN
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
`endif

    muller_c_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (c_out_i),
        .q_o   (c_sync)
    );

    // Completed-handshake count, held at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    // Next-state, output and bookkeeping logic for the handshake sequencer.
    always_comb begin
        state_d   = state_q;
        c_in_d    = c_in_q;
        timer_d   = timer_q;
        lat_d     = lat_q;
        cnt_d     = cnt_q;
        ncyc_d    = ncyc_q;
        err_to_d  = err_to_q;
        err_pre_d = err_pre_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
`ifdef MULLER_HS_STAGGER_EN
        idx_d     = idx_q;
        gap_d     = gap_q;
`endif

        if (state_q != IDLE && stop_i) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i && !c_sync) begin
                    state_d   = RISE;
                    c_in_d    = RISE_ENTRY;
                    cnt_d     = '0;
                    lat_d     = '0;
                    err_to_d  = 1'b0;
                    err_pre_d = 1'b0;
                    ncyc_d    = n_cycles_i;
                    // A stop arriving with the start limits the run to one handshake.
                    stop_d    = stop_i;
`ifdef MULLER_HS_STAGGER_EN
                    idx_d     = IDX_W'(1);
                    gap_d     = GAP_W'(1);
`endif
                end
            end

            RISE: begin
                if (c_sync && !(&c_in_q)) begin
                    err_pre_d = 1'b1;
                end
`ifdef MULLER_HS_STAGGER_EN
                if (gap_q == GAP_W'(STAGGER_GAP)) begin
                    if (idx_q == IDX_W'(N_IN)) begin
                        state_d = WAIT_HI;
                        timer_d = TIMER_ONE;
                    end else begin
                        c_in_d = c_in_q | (N_IN'(1) << idx_q);
                        idx_d  = idx_q + 1'b1;
                        gap_d  = GAP_W'(1);
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
`else
                state_d = WAIT_HI;
                timer_d = TIMER_ONE;
`endif
            end

            WAIT_HI: begin
                if (c_sync) begin
                    if (timer_q > lat_q) begin
                        lat_d = timer_q;
                    end
                    state_d = FALL;
                    c_in_d  = FALL_ENTRY;
`ifdef MULLER_HS_STAGGER_EN
                    idx_d   = IDX_W'(1);
                    gap_d   = GAP_W'(1);
`endif
                end else if (timer_q == TIMER_MAX) begin
                    err_to_d = 1'b1;
                    c_in_d   = '0;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    stop_d   = 1'b0;
                end else begin
                    // Never passes TIMEOUT: reaching it always leaves this state.
                    timer_d = timer_q + 1'b1;
                end
            end

            FALL: begin
                if (!c_sync && (|c_in_q)) begin
                    err_pre_d = 1'b1;
                end
`ifdef MULLER_HS_STAGGER_EN
                if (gap_q == GAP_W'(STAGGER_GAP)) begin
                    if (idx_q == IDX_W'(N_IN)) begin
                        state_d = WAIT_LO;
                        timer_d = TIMER_ONE;
                    end else begin
                        c_in_d = c_in_q & ~(N_IN'(1) << idx_q);
                        idx_d  = idx_q + 1'b1;
                        gap_d  = GAP_W'(1);
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
`else
                state_d = WAIT_LO;
                timer_d = TIMER_ONE;
`endif
            end

            WAIT_LO: begin
                if (!c_sync) begin
                    if (timer_q > lat_q) begin
                        lat_d = timer_q;
                    end
                    cnt_d = cnt_inc;
                    if ((ncyc_q != '0 && cnt_inc == ncyc_q) || stop_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = RISE;
                        c_in_d  = RISE_ENTRY;
`ifdef MULLER_HS_STAGGER_EN
                        idx_d   = IDX_W'(1);
                        gap_d   = GAP_W'(1);
`endif
                    end
                end else if (timer_q == TIMER_MAX) begin
                    err_to_d = 1'b1;
                    c_in_d   = '0;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    stop_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                c_in_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    // Sequencer state and all registered outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            c_in_q    <= '0;
            timer_q   <= '0;
            lat_q     <= '0;
            cnt_q     <= '0;
            ncyc_q    <= '0;
            err_to_q  <= 1'b0;
            err_pre_q <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_in_q    <= c_in_d;
            timer_q   <= timer_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            ncyc_q    <= ncyc_d;
            err_to_q  <= err_to_d;
            err_pre_q <= err_pre_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
        end
    end

`ifdef MULLER_HS_STAGGER_EN
    // Stagger position: next input bit to move and cycles since the last move.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q <= '0;
            gap_q <= '0;
        end else begin
            idx_q <= idx_d;
            gap_q <= gap_d;
        end
    end
`endif

    assign c_in_o          = c_in_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign cycles_done_o   = cnt_q;
    assign lat_max_o       = lat_q;
    assign err_timeout_o   = err_to_q;
    assign err_premature_o = err_pre_q;

endmodule : muller_c_hs_driver

// File: tb/tb_muller_c_hs_driver.sv
// Self-checking bench for muller_c_hs_driver. A behavioural C-element (or a
// faulty OR gate, or a tied-off output) sits on c_in_o/c_out_i; its output
// settles 2.5 clock periods after the inputs move, so it is first captured by
// the synchronizer on the third rising edge after the inputs change.
module tb_muller_c_hs_driver;

    localparam int N_IN = 3;
    localparam int GAP  = 4;

    // Expected timings. Default build: a handshake takes 10 cycles (RISE 1,
    // WAIT_HI 4, FALL 1, WAIT_LO 4) and each wait observes c_sync at timer 4.
    // Staggered: RISE and FALL each take N_IN*GAP cycles, the output has already
    // settled when each wait starts (timer 1), and the OR gate trips the
    // premature check while bit 2 is still low.
`ifdef MULLER_HS_STAGGER_EN
    localparam int HS       = 2 * N_IN * GAP + 2;
    localparam int LAT      = 1;
    localparam int PRE_OR   = 1;
    localparam int TO_TICKS = N_IN * GAP + 200;
`else
    localparam int HS       = 10;
    localparam int LAT      = 4;
    localparam int PRE_OR   = 0;
    localparam int TO_TICKS = 1 + 200;
`endif

    localparam logic [1:0] M_CEL = 2'd0;
    localparam logic [1:0] M_OR  = 2'd1;
    localparam logic [1:0] M_LO  = 2'd2;
    localparam logic [1:0] M_HI  = 2'd3;

    logic            clk;
    logic            rst;
    logic            start;
    logic            stop;
    logic [15:0]     n_cycles;
    logic            c_out;
    logic [N_IN-1:0] c_in_o;
    logic            busy_o;
    logic            done_o;
    logic [15:0]     cycles_done_o;
    logic [7:0]      lat_max_o;
    logic            err_timeout_o;
    logic            err_premature_o;

    logic [1:0]      mode;
    logic            d1, d2, d3;

    int checks = 0;
    int passed = 0;

    muller_c_hs_driver #(
        .N_IN        (N_IN),
        .SYNC_STAGES (2),
        .TIMEOUT_W   (8),
        .TIMEOUT     (200),
        .CNT_W       (16),
        .STAGGER_GAP (GAP)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .start_i         (start),
        .stop_i          (stop),
        .n_cycles_i      (n_cycles),
        .c_out_i         (c_out),
        .c_in_o          (c_in_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cycles_done_o   (cycles_done_o),
        .lat_max_o       (lat_max_o),
        .err_timeout_o   (err_timeout_o),
        .err_premature_o (err_premature_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        d1 = 1'b0;
        d2 = 1'b0;
        d3 = 1'b0;
    end

    // Load model: d1 holds the element's target value (C-element keeps its
    // previous value while inputs disagree), d2/d3 add the response delay.
    always @(negedge clk) begin
        if (mode == M_OR) d1 <= |c_in_o;
        else if (&c_in_o) d1 <= 1'b1;
        else if (~|c_in_o) d1 <= 1'b0;
        d2 <= d1;
        d3 <= d2;
    end

    assign c_out = (mode == M_LO) ? 1'b0 : (mode == M_HI) ? 1'b1 : d3;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [15:0] ncyc;
        int          ticks;
        logic [15:0] cycles;
        logic [7:0]  lat;
        logic        to;
        logic        pre;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        n_cycles = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Cycles until done_o is seen, or -1 if the bound expires first.
    task automatic wait_done(input int bound, output int ticks);
        ticks = 0;
        while (done_o !== 1'b1 && ticks < bound) begin
            tick();
            ticks++;
        end
        if (done_o !== 1'b1) ticks = -1;
    endtask

    initial begin
        int n;
        int t;

        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        n_cycles = '0;
        mode     = M_CEL;

        //            name        mode   ncyc ticks     cycles lat  to    pre
        vecs[0] = '{"run3",    M_CEL, 16'd3, 3 * HS,   16'd3, 8'(LAT), 1'b0, 1'b0};
        vecs[1] = '{"timeout", M_LO,  16'd3, TO_TICKS, 16'd0, 8'd0,    1'b1, 1'b0};
        vecs[2] = '{"or_gate", M_OR,  16'd1, HS,       16'd1, 8'(LAT), 1'b0, 1'(PRE_OR)};
        vecs[3] = '{"run1",    M_CEL, 16'd1, HS,       16'd1, 8'(LAT), 1'b0, 1'b0};

        repeat (3) tick();
        check("rst c_in",    32'(c_in_o), 0);
        check("rst busy",    32'(busy_o), 0);
        check("rst done",    32'(done_o), 0);
        check("rst cycles",  32'(cycles_done_o), 0);
        check("rst lat",     32'(lat_max_o), 0);
        check("rst err_to",  32'(err_timeout_o), 0);
        check("rst err_pre", 32'(err_premature_o), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            repeat (4) tick();
            pulse_start(vecs[i].ncyc);
            check({vecs[i].name, " busy"}, 32'(busy_o), 1);
            wait_done(3000, t);
            check({vecs[i].name, " run length"}, 32'(t), 32'(vecs[i].ticks));
            check({vecs[i].name, " cycles"}, 32'(cycles_done_o), 32'(vecs[i].cycles));
            check({vecs[i].name, " lat"}, 32'(lat_max_o), 32'(vecs[i].lat));
            check({vecs[i].name, " err_to"}, 32'(err_timeout_o), 32'(vecs[i].to));
            check({vecs[i].name, " err_pre"}, 32'(err_premature_o), 32'(vecs[i].pre));
            check({vecs[i].name, " c_in idle"}, 32'(c_in_o), 0);
            check({vecs[i].name, " busy end"}, 32'(busy_o), 0);
            tick();
            check({vecs[i].name, " done width"}, 32'(done_o), 0);
        end

        // Free-running run stopped during the 5th handshake.
        mode = M_CEL;
        repeat (4) tick();
        pulse_start(16'd0);
        n = 0;
        while (cycles_done_o != 16'd4 && n < 2000) begin
            tick();
            n++;
        end
        check("stop reached 4", 32'(cycles_done_o), 4);
        repeat (2) tick();
        check("stop 5th busy", 32'(busy_o), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(2000, t);
        check("stop done seen", 32'(t != -1), 1);
        check("stop cycles", 32'(cycles_done_o), 5);
        check("stop c_in", 32'(c_in_o), 0);
        check("stop busy", 32'(busy_o), 0);
        tick();
        check("stop done width", 32'(done_o), 0);

        // Start while the C-element output is already high must be ignored.
        mode = M_HI;
        repeat (4) tick();
        pulse_start(16'd1);
        repeat (2) tick();
        check("hi start busy", 32'(busy_o), 0);
        check("hi start cycles", 32'(cycles_done_o), 5);
        check("hi start lat", 32'(lat_max_o), 32'(LAT));
        check("hi start c_in", 32'(c_in_o), 0);

        // Start while busy is ignored; reset mid-run clears everything at once.
        mode = M_CEL;
        repeat (4) tick();
        pulse_start(16'd2);
        n = 0;
        while (cycles_done_o != 16'd1 && n < 2000) begin
            tick();
            n++;
        end
        check("busy start reached 1", 32'(cycles_done_o), 1);
        tick();
        pulse_start(16'd0);
        tick();
        check("busy start cycles", 32'(cycles_done_o), 1);
        check("busy start busy", 32'(busy_o), 1);
        check("busy start lat", 32'(lat_max_o), 32'(LAT));
        #3;
        rst = 1'b1;
        #1;
        check("async rst c_in", 32'(c_in_o), 0);
        check("async rst busy", 32'(busy_o), 0);
        check("async rst cycles", 32'(cycles_done_o), 0);
        check("async rst lat", 32'(lat_max_o), 0);
        check("async rst done", 32'(done_o), 0);
        rst = 1'b0;
        tick();
        tick();
        check("post rst busy", 32'(busy_o), 0);
        check("post rst c_in", 32'(c_in_o), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_muller_c_hs_driver
